// File: rtl/output_sample_stage_pkg.sv
// Shared constants and the saturation helper for the output sample stage.
package output_sample_stage_pkg;

  localparam logic [15:0] OUT_GAIN_UNITY     = 16'h1000;
  localparam int          OUT_GAIN_FRAC_BITS = 12;
  localparam logic [15:0] OUT_RAMP_STEP      = 16'h0080;
  localparam int          SAT_WIDTH          = 48;

  // Clamp a signed value into the range of a signed `width`-bit word.
  function automatic logic signed [SAT_WIDTH-1:0] sat_to_width(
    input logic signed [SAT_WIDTH-1:0] val,
    input int                          width
  );
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    max_v = (48'sd1 <<< (width - 1)) - 48'sd1;
    min_v = -(48'sd1 <<< (width - 1));
    if (val > max_v) begin
      sat_to_width = max_v;
    end else if (val < min_v) begin
      sat_to_width = min_v;
    end else begin
      sat_to_width = val;
    end
  endfunction

endpackage

// File: rtl/output_sample_stage_sample_fifo.sv
// Synchronous sample FIFO; pop on empty is ignored, push on full is dropped unless a pop frees a slot.
module sample_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rd_data   = mem_r[rd_ptr_r];
  assign level     = count_r;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/output_sample_stage.sv
// Captures engine samples into a FIFO, applies Q4.12 gain with saturation and emits one 24-bit sample per I2S frame.
// Optional feature macro: OUTPUT_STAGE_SOFT_MUTE_EN (per-frame gain ramp for mute).
module output_sample_stage
  import output_sample_stage_pkg::*;
#(
  parameter  int IN_WIDTH   = 16,
  parameter  int OUT_WIDTH  = 24,
  parameter  int FIFO_DEPTH = 4,
  parameter  int GAIN_WIDTH = 16,
  localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_sample,
  input  logic                 engine_ready,
  input  logic                 lrclk,
  input  logic [GAIN_WIDTH-1:0] gain_in,
  input  logic                 gain_write,
  input  logic                 mute,
  output logic [OUT_WIDTH-1:0] out_sample,
  output logic                 out_valid,
  output logic [LVL_WIDTH-1:0] fifo_level,
  output logic [15:0]          underrun_count,
  output logic                 overflow
);

  localparam int PW    = IN_WIDTH + GAIN_WIDTH + 1;
  // Widening by OUT-IN bits and dropping FRAC bits collapse into one right shift.
  localparam int SHIFT = OUT_GAIN_FRAC_BITS - (OUT_WIDTH - IN_WIDTH);

  logic                        engine_ready_q_r;
  logic                        lrclk_q_r;
  logic                        push_s;
  logic                        tick_s;
  logic [IN_WIDTH-1:0]         head_s;
  logic                        full_s;
  logic                        empty_s;
  logic [GAIN_WIDTH-1:0]       gain_r;
  logic [GAIN_WIDTH-1:0]       gain_eff_s;
  logic signed [IN_WIDTH-1:0]  x_sel_s;
  logic signed [IN_WIDTH-1:0]  last_r;
  logic signed [PW-1:0]        prod_r;
  logic                        s1_valid_r;

  assign push_s = engine_ready && !engine_ready_q_r;
  assign tick_s = lrclk_q_r && !lrclk;

  sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (tick_s),
    .wr_data (in_sample),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (fifo_level)
  );

  // Edge-detect history for engine ready and word select
  always_ff @(posedge clk) begin
    if (reset) begin
      engine_ready_q_r <= 1'b0;
      lrclk_q_r        <= 1'b0;
    end else begin
      engine_ready_q_r <= engine_ready;
      lrclk_q_r        <= lrclk;
    end
  end

  // Programmed gain; the tick consumes the value held before any same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      gain_r <= GAIN_WIDTH'(OUT_GAIN_UNITY);
    end else if (gain_write) begin
      gain_r <= gain_in;
    end
  end

`ifdef OUTPUT_STAGE_SOFT_MUTE_EN
  logic [GAIN_WIDTH-1:0] ramp_r;
  logic [GAIN_WIDTH-1:0] ramp_next_s;
  localparam logic [GAIN_WIDTH-1:0] RAMP = GAIN_WIDTH'(OUT_RAMP_STEP);

  // Next ramp value: head toward 0 when muted, else toward the current gain target
  always_comb begin
    ramp_next_s = ramp_r;
    if (mute) begin
      if (ramp_r > RAMP) ramp_next_s = ramp_r - RAMP;
      else               ramp_next_s = '0;
    end else if (ramp_r < gain_r) begin
      if ((gain_r - ramp_r) > RAMP) ramp_next_s = ramp_r + RAMP;
      else                          ramp_next_s = gain_r;
    end else if (ramp_r > gain_r) begin
      if ((ramp_r - gain_r) > RAMP) ramp_next_s = ramp_r - RAMP;
      else                          ramp_next_s = gain_r;
    end else begin
      ramp_next_s = ramp_r;
    end
  end

  // Ramp advances once per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_r <= GAIN_WIDTH'(OUT_GAIN_UNITY);
    end else if (tick_s) begin
      ramp_r <= ramp_next_s;
    end
  end

  assign gain_eff_s = ramp_next_s;
`else
  assign gain_eff_s = mute ? '0 : gain_r;
`endif

  // Stage 0 selection: fresh head, or repeat the last sample on underrun
  always_comb begin
    x_sel_s = last_r;
    if (!empty_s) begin
      x_sel_s = $signed(head_s);
    end else begin
      x_sel_s = last_r;
    end
  end

  // Multiply / saturate pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r     <= '0;
      prod_r     <= '0;
      s1_valid_r <= 1'b0;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      s1_valid_r <= tick_s;
      out_valid  <= s1_valid_r;
      if (tick_s) begin
        last_r <= x_sel_s;
        prod_r <= PW'(x_sel_s) * PW'($signed({1'b0, gain_eff_s}));
      end
      if (s1_valid_r) begin
        out_sample <= OUT_WIDTH'(sat_to_width(SAT_WIDTH'(prod_r >>> SHIFT), OUT_WIDTH));
      end
    end
  end

  // Underrun counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= 16'h0000;
      overflow       <= 1'b0;
    end else begin
      if (tick_s && empty_s && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'h0001;
      end
      if (push_s && full_s && !tick_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_sample_stage.sv
// Directed, table-driven bench for output_sample_stage.
module tb_output_sample_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_sample = 16'h0000;
  logic        engine_ready = 1'b0;
  logic        lrclk = 1'b1;
  logic [15:0] gain_in = 16'h0000;
  logic        gain_write = 1'b0;
  logic        mute = 1'b0;
  logic [23:0] out_sample;
  logic        out_valid;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;
  logic        overflow;

  int vec_count = 0;
  int err_count = 0;

  typedef struct {
    logic [15:0] smp;
    logic [15:0] gain;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[8];

  output_sample_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_sample      (in_sample),
    .engine_ready   (engine_ready),
    .lrclk          (lrclk),
    .gain_in        (gain_in),
    .gain_write     (gain_write),
    .mute           (mute),
    .out_sample     (out_sample),
    .out_valid      (out_valid),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; engine_ready = 1'b0; lrclk = 1'b1; gain_write = 1'b0; mute = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] s);
    @(negedge clk);
    in_sample = s; engine_ready = 1'b1;
    @(negedge clk);
    engine_ready = 1'b0;
  endtask

  task automatic write_gain(input logic [15:0] g);
    @(negedge clk);
    gain_in = g; gain_write = 1'b1;
    @(negedge clk);
    gain_write = 1'b0;
  endtask

  // One frame: optional same-cycle push and gain write; checks the 2-cycle valid latency.
  task automatic frame(input logic push_en, input logic [15:0] s, input logic gw,
                       input logic [15:0] gv, output logic [23:0] got);
    @(negedge clk);
    lrclk = 1'b0;
    if (push_en) begin in_sample = s; engine_ready = 1'b1; end
    gain_write = gw; gain_in = gv;
    @(negedge clk);
    check("valid_early", {31'd0, out_valid}, 32'd0);
    lrclk = 1'b1; engine_ready = 1'b0; gain_write = 1'b0;
    @(negedge clk);
    check("valid_at_2", {31'd0, out_valid}, 32'd1);
    got = out_sample;
    @(negedge clk);
    check("valid_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [23:0] got;
    logic [23:0] prev;
    logic [23:0] exp_seq [4];
    logic [31:0] g_exp;

    vecs[0] = '{16'h1234, 16'h1000, 24'h123400};
    vecs[1] = '{16'h7000, 16'h4000, 24'h7FFFFF};
    vecs[2] = '{16'h8000, 16'h4000, 24'h800000};
    vecs[3] = '{16'hFFFF, 16'h1000, 24'hFFFF00};
    vecs[4] = '{16'h0100, 16'h0800, 24'h008000};
    vecs[5] = '{16'hFFFF, 16'h0800, 24'hFFFF80};
    vecs[6] = '{16'h4000, 16'h2000, 24'h7FFFFF};
    vecs[7] = '{16'h7FFF, 16'h1000, 24'h7FFF00};

    do_reset();
    check("rst_out_sample", {8'd0, out_sample}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_underrun", {16'd0, underrun_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      write_gain(vecs[i].gain);
      push(vecs[i].smp);
      check("vec_level_push", {29'd0, fifo_level}, 32'd1);
      frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
      check($sformatf("vec%0d_out", i), {8'd0, got}, {8'd0, vecs[i].exp});
      check("vec_level_pop", {29'd0, fifo_level}, 32'd0);
    end
    check("vec_underrun", {16'd0, underrun_count}, 32'd0);

    // Overflow on the fifth push, then in-order drain
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(16'(i * 16'h0011));
      if (i == 4) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    end
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
      check("ovf_drain", {8'd0, got}, 32'(i * 32'h1100));
    end
    check("ovf_level_end", {29'd0, fifo_level}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_underrun", {16'd0, underrun_count}, 32'd0);

    // Underrun repeats the last sample
    do_reset();
    push(16'h0100);
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
      check("urun_repeat", {8'd0, got}, 32'h010000);
    end
    check("urun_count", {16'd0, underrun_count}, 32'd2);

    // Simultaneous push and pop
    do_reset();
    push(16'h0A00);
    push(16'h0B00);
    frame(1'b1, 16'h0C00, 1'b0, 16'h0000, got);
    check("sim_l2_out", {8'd0, got}, 32'h0A0000);
    check("sim_l2_level", {29'd0, fifo_level}, 32'd2);
    push(16'h0D00);
    push(16'h0E00);
    check("sim_full_level", {29'd0, fifo_level}, 32'd4);
    frame(1'b1, 16'h0F00, 1'b0, 16'h0000, got);
    check("sim_l4_out", {8'd0, got}, 32'h0B0000);
    check("sim_l4_level", {29'd0, fifo_level}, 32'd4);
    check("sim_l4_no_ovf", {31'd0, overflow}, 32'd0);
    exp_seq[0] = 24'h0C0000; exp_seq[1] = 24'h0D0000;
    exp_seq[2] = 24'h0E0000; exp_seq[3] = 24'h0F0000;
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
      check("sim_drain", {8'd0, got}, {8'd0, exp_seq[i]});
    end
    frame(1'b1, 16'h0100, 1'b0, 16'h0000, got);
    check("sim_empty_out", {8'd0, got}, 32'h0F0000);
    check("sim_empty_urun", {16'd0, underrun_count}, 32'd1);
    check("sim_empty_level", {29'd0, fifo_level}, 32'd1);
    frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
    check("sim_empty_next", {8'd0, got}, 32'h010000);

    // Gain write on the tick cycle applies to the following frame
    push(16'h0200);
    push(16'h0200);
    frame(1'b0, 16'h0000, 1'b1, 16'h2000, got);
    check("gain_tick_same", {8'd0, got}, 32'h020000);
    frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
    check("gain_tick_next", {8'd0, got}, 32'h040000);

    // Reset while a frame is in flight
    push(16'h3000);
    @(negedge clk);
    lrclk = 1'b0;
    @(negedge clk);
    lrclk = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out", {8'd0, out_sample}, 32'd0);
    check("midrst_level", {29'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
    check("midrst_first", {8'd0, got}, 32'd0);
    check("midrst_urun", {16'd0, underrun_count}, 32'd1);

    // Mute at unity
    do_reset();
`ifdef OUTPUT_STAGE_SOFT_MUTE_EN
    push(16'h1000);
    mute = 1'b1;
    prev = 24'h7FFFFF;
    for (int k = 1; k <= 32; k++) begin
      frame(1'b1, 16'h1000, 1'b0, 16'h0000, got);
      g_exp = 32'h1000 - 32'(k) * 32'h80;
      check("ramp_step", {8'd0, got}, g_exp << 8);
      if ($signed(got) > $signed(prev)) check("ramp_monotonic", {8'd0, got}, {8'd0, prev});
      prev = got;
    end
    check("ramp_zero", {8'd0, got}, 32'd0);
    mute = 1'b0;
`else
    push(16'h1234);
    mute = 1'b1;
    frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
    check("mute_out", {8'd0, got}, 32'd0);
    mute = 1'b0;
    push(16'h1234);
    frame(1'b0, 16'h0000, 1'b0, 16'h0000, got);
    check("unmute_out", {8'd0, got}, 32'h123400);
    check("mute_urun", {16'd0, underrun_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
